// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between EXU and mem with alignment check and WBU response register
module lsu_ctrl #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   output logic        mem_valid,
   output logic        mem_wen,
   output logic [2:0]  mem_readop,
   output logic [7:0]  mem_wmask,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_misalign
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t      state;
   logic        ld_q;
   logic [3:0]  cnt;
   logic        is_ld, is_st, mis;
   logic [3:0]  wm;
   logic [4:0]  sh;
   logic [31:0] wd;
   // decode request: legal op class, alignment fault, byte-lane mask and shifted store data
   always_comb begin
      is_ld = in_load && (in_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      is_st = in_store && in_funct3 < 3'd3;
      mis = (in_funct3[1:0] == 2'd1 && in_addr[0]) || (in_funct3[1:0] == 2'd2 && in_addr[1:0] != 2'd0);
      sh = {in_addr[1:0], 3'b000};
      wm = in_funct3[1:0] == 2'd0 ? 4'b0001 << in_addr[1:0] : in_funct3[1:0] == 2'd1 ? 4'b0011 << in_addr[1:0] : 4'hF;
      wd = in_funct3[1:0] == 2'd0 ? {24'd0, in_wdata[7:0]} << sh : in_funct3[1:0] == 2'd1 ? {16'd0, in_wdata[15:0]} << sh : in_wdata;
   end
   assign in_ready = state == IDLE && !rst;
   // sequencer: accept, drive mem strobes for the access, hold response until WBU takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ld_q <= 1'b0;
         cnt <= 4'd0;
         mem_valid <= 1'b0;
         mem_wen <= 1'b0;
         mem_readop <= 3'd0;
         mem_wmask <= 8'd0;
         mem_raddr <= 32'd0;
         mem_waddr <= 32'd0;
         mem_wdata <= 32'd0;
         out_valid <= 1'b0;
         out_rdata <= 32'd0;
         out_misalign <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               mem_readop <= in_funct3;
               mem_raddr <= in_addr;
               mem_waddr <= in_addr;
               ld_q <= is_ld;
               cnt <= 4'(MEM_LAT - 1);
               out_rdata <= 32'd0;
               out_misalign <= 1'b0;
               if (!(is_ld || is_st)) begin
                  out_valid <= 1'b1;
                  state <= RESP;
               end else if (mis) begin
                  out_misalign <= 1'b1;
                  out_valid <= 1'b1;
                  state <= RESP;
               end else begin
                  mem_valid <= is_ld;
                  mem_wen <= is_st;
                  mem_wmask <= is_st ? {4'd0, wm} : 8'd0;
                  mem_wdata <= is_st ? wd : 32'd0;
                  state <= ACCESS;
               end
            end
            ACCESS: if (!ld_q) begin
               mem_wen <= 1'b0;
               mem_wmask <= 8'd0;
               out_valid <= 1'b1;
               state <= RESP;
            end else if (cnt == 4'd0) begin
               mem_valid <= 1'b0;
               out_rdata <= mem_rdata;
               out_valid <= 1'b1;
               state <= RESP;
            end else begin
               cnt <= cnt - 4'd1;
            end
            RESP: if (out_ready) begin
               out_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl at MEM_LAT=1 (a_*) and MEM_LAT=4 (b_*)
module tb_lsu_ctrl;
   logic        clk = 1'b0, rst = 1'b1, a_v = 1'b0, b_v = 1'b0;
   logic        in_load = 1'b0, in_store = 1'b0, out_ready = 1'b1;
   logic [2:0]  in_funct3 = 3'd0;
   logic [31:0] in_addr = 32'd0, in_wdata = 32'd0, mem_rdata = 32'd0;
   logic        a_in_ready, a_mem_valid, a_mem_wen, a_out_valid, a_out_misalign;
   logic        b_in_ready, b_mem_valid, b_mem_wen, b_out_valid, b_out_misalign;
   logic [2:0]  a_mem_readop, b_mem_readop;
   logic [7:0]  a_mem_wmask, b_mem_wmask;
   logic [31:0] a_mem_raddr, a_mem_waddr, a_mem_wdata, a_out_rdata;
   logic [31:0] b_mem_raddr, b_mem_waddr, b_mem_wdata, b_out_rdata;
   int n_run = 0, n_fail = 0;

   lsu_ctrl #(.MEM_LAT(1)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_v), .in_ready(a_in_ready), .in_load(in_load), .in_store(in_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .mem_valid(a_mem_valid), .mem_wen(a_mem_wen),
      .mem_readop(a_mem_readop), .mem_wmask(a_mem_wmask), .mem_raddr(a_mem_raddr), .mem_waddr(a_mem_waddr),
      .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_rdata(a_out_rdata), .out_misalign(a_out_misalign));

   lsu_ctrl #(.MEM_LAT(4)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_v), .in_ready(b_in_ready), .in_load(in_load), .in_store(in_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .mem_valid(b_mem_valid), .mem_wen(b_mem_wen),
      .mem_readop(b_mem_readop), .mem_wmask(b_mem_wmask), .mem_raddr(b_mem_raddr), .mem_waddr(b_mem_waddr),
      .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_rdata(b_out_rdata), .out_misalign(b_out_misalign));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
      in_load = ld;
      in_store = st;
      in_funct3 = f3;
      in_addr = ad;
      in_wdata = wd;
   endtask

   initial begin
      tick;
      tick;
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_mem_valid", 32'(a_mem_valid), 32'd0);
      chk("rst_mem_wen", 32'(a_mem_wen), 32'd0);
      chk("rst_out_rdata", a_out_rdata, 32'd0);
      chk("rst_wmask", 32'(a_mem_wmask), 32'd0);
      rst = 1'b0;
      tick;
      chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
      // lw, MEM_LAT=1
      req(1, 0, 3'd2, 32'h8000_0008, 32'd0);
      mem_rdata = 32'hDEAD_BEEF;
      a_v = 1'b1;
      tick;
      a_v = 1'b0;
      chk("lw_c1_mem_valid", 32'(a_mem_valid), 32'd1);
      chk("lw_c1_readop", 32'(a_mem_readop), 32'd2);
      chk("lw_c1_raddr", a_mem_raddr, 32'h8000_0008);
      chk("lw_c1_out_valid", 32'(a_out_valid), 32'd0);
      chk("lw_c1_in_ready", 32'(a_in_ready), 32'd0);
      chk("lw_c1_wen", 32'(a_mem_wen), 32'd0);
      tick;
      chk("lw_c2_mem_valid", 32'(a_mem_valid), 32'd0);
      chk("lw_c2_out_valid", 32'(a_out_valid), 32'd1);
      chk("lw_c2_rdata", a_out_rdata, 32'hDEAD_BEEF);
      chk("lw_c2_misalign", 32'(a_out_misalign), 32'd0);
      tick;
      chk("lw_done_out_valid", 32'(a_out_valid), 32'd0);
      chk("lw_done_in_ready", 32'(a_in_ready), 32'd1);
      // sb lane 3
      req(0, 1, 3'd0, 32'h8000_0003, 32'h1234_56AB);
      a_v = 1'b1;
      tick;
      a_v = 1'b0;
      chk("sb_c1_wen", 32'(a_mem_wen), 32'd1);
      chk("sb_c1_wmask", 32'(a_mem_wmask), 32'h08);
      chk("sb_c1_wdata", a_mem_wdata, 32'hAB00_0000);
      chk("sb_c1_waddr", a_mem_waddr, 32'h8000_0003);
      chk("sb_c1_mem_valid", 32'(a_mem_valid), 32'd0);
      chk("sb_c1_out_valid", 32'(a_out_valid), 32'd0);
      tick;
      chk("sb_c2_wen", 32'(a_mem_wen), 32'd0);
      chk("sb_c2_wmask", 32'(a_mem_wmask), 32'd0);
      chk("sb_c2_out_valid", 32'(a_out_valid), 32'd1);
      chk("sb_c2_rdata", a_out_rdata, 32'd0);
      tick;
      // sh lane 2 (aligned)
      req(0, 1, 3'd1, 32'h8000_0002, 32'h89AB_CDEF);
      a_v = 1'b1;
      tick;
      a_v = 1'b0;
      chk("sh_c1_wmask", 32'(a_mem_wmask), 32'h0C);
      chk("sh_c1_wdata", a_mem_wdata, 32'hCDEF_0000);
      tick;
      tick;
      // sw
      req(0, 1, 3'd2, 32'h8000_0004, 32'h0102_0304);
      a_v = 1'b1;
      tick;
      a_v = 1'b0;
      chk("sw_c1_wmask", 32'(a_mem_wmask), 32'h0F);
      chk("sw_c1_wdata", a_mem_wdata, 32'h0102_0304);
      tick;
      tick;
      // misaligned sh
      req(0, 1, 3'd1, 32'h8000_0001, 32'hFFFF_FFFF);
      a_v = 1'b1;
      tick;
      a_v = 1'b0;
      chk("sh_mis_wen", 32'(a_mem_wen), 32'd0);
      chk("sh_mis_out_valid", 32'(a_out_valid), 32'd1);
      chk("sh_mis_flag", 32'(a_out_misalign), 32'd1);
      chk("sh_mis_wmask", 32'(a_mem_wmask), 32'd0);
      tick;
      chk("sh_mis_in_ready", 32'(a_in_ready), 32'd1);
      // misaligned lw
      req(1, 0, 3'd2, 32'h8000_0006, 32'd0);
      a_v = 1'b1;
      tick;
      a_v = 1'b0;
      chk("lw_mis_mem_valid", 32'(a_mem_valid), 32'd0);
      chk("lw_mis_out_valid", 32'(a_out_valid), 32'd1);
      chk("lw_mis_flag", 32'(a_out_misalign), 32'd1);
      chk("lw_mis_rdata", a_out_rdata, 32'd0);
      tick;
      // no-op and illegal load funct3
      req(0, 0, 3'd2, 32'h8000_0001, 32'd0);
      a_v = 1'b1;
      tick;
      a_v = 1'b0;
      chk("noop_out_valid", 32'(a_out_valid), 32'd1);
      chk("noop_flag", 32'(a_out_misalign), 32'd0);
      tick;
      req(1, 0, 3'd3, 32'h8000_0000, 32'd0);
      a_v = 1'b1;
      tick;
      a_v = 1'b0;
      chk("ld_f3_3_mem_valid", 32'(a_mem_valid), 32'd0);
      chk("ld_f3_3_out_valid", 32'(a_out_valid), 32'd1);
      tick;
      // stalled response
      req(1, 0, 3'd2, 32'h8000_0000, 32'd0);
      mem_rdata = 32'h1122_3344;
      out_ready = 1'b0;
      a_v = 1'b1;
      tick;
      a_v = 1'b0;
      tick;
      req(0, 1, 3'd2, 32'h8000_0010, 32'h5555_5555);
      mem_rdata = 32'd0;
      a_v = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_out_valid", 32'(a_out_valid), 32'd1);
         chk("stall_rdata", a_out_rdata, 32'h1122_3344);
         chk("stall_in_ready", 32'(a_in_ready), 32'd0);
         chk("stall_wen", 32'(a_mem_wen), 32'd0);
         tick;
      end
      a_v = 1'b0;
      out_ready = 1'b1;
      tick;
      chk("stall_release_out_valid", 32'(a_out_valid), 32'd0);
      chk("stall_release_in_ready", 32'(a_in_ready), 32'd1);
      chk("stall_release_wen", 32'(a_mem_wen), 32'd0);
      // lbu, MEM_LAT=4
      req(1, 0, 3'd4, 32'h8000_0001, 32'd0);
      b_v = 1'b1;
      tick;
      b_v = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk("lbu_mem_valid", 32'(b_mem_valid), 32'd1);
         chk("lbu_out_valid", 32'(b_out_valid), 32'd0);
         mem_rdata = 32'h100 + 32'(c);
         tick;
      end
      chk("lbu_c5_mem_valid", 32'(b_mem_valid), 32'd0);
      chk("lbu_c5_out_valid", 32'(b_out_valid), 32'd1);
      chk("lbu_c5_rdata", b_out_rdata, 32'h104);
      chk("lbu_c5_readop", 32'(b_mem_readop), 32'd4);
      tick;
      // reset in cycle 2 of a MEM_LAT=4 load
      req(1, 0, 3'd2, 32'h8000_0010, 32'd0);
      mem_rdata = 32'hCAFE_F00D;
      b_v = 1'b1;
      tick;
      b_v = 1'b0;
      tick;
      chk("rstld_c2_mem_valid", 32'(b_mem_valid), 32'd1);
      rst = 1'b1;
      tick;
      chk("rstld_mem_valid", 32'(b_mem_valid), 32'd0);
      chk("rstld_out_valid", 32'(b_out_valid), 32'd0);
      chk("rstld_in_ready", 32'(b_in_ready), 32'd0);
      rst = 1'b0;
      tick;
      chk("rstld_after_in_ready", 32'(b_in_ready), 32'd1);
      chk("rstld_after_mem_valid", 32'(b_mem_valid), 32'd0);
      chk("rstld_after_out_valid", 32'(b_out_valid), 32'd0);
      chk("rstld_after_rdata", b_out_rdata, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
